// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types and helpers for the multi-port integer register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF = 32;
    localparam int c_max_wr = 4;

    // Highest set bit of the hit vector; caller qualifies with |hit.
    function automatic logic [1:0] wr_winner(input logic [c_max_wr-1:0] hit);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < c_max_wr; i++) begin
            if (hit[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clr_ctrl.sv
// ============================================================================
// Module : regfile_clr_ctrl
// Brief  : Sequential clear engine: walks every entry once after reset or on
//          request, raising busy while it runs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_clr_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     r_state;
    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == AW'(DEPTH - 1)) r_state <= READY;
                    else                         r_ptr   <= r_ptr + AW'(1);
                end
                READY: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Reset forces busy so reads are already zero before the first edge.
    assign busy     = reset | (r_state == CLEAR);
    assign clr_we   = !reset && (r_state == CLEAR);
    assign clr_addr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Parametrised multi-port register file with write priority,
//          same-cycle bypass, optional hardwired x0 and a clear engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr_req,
    output logic                        busy,
    input  logic [NWRITE-1:0]           we,
    input  logic [NWRITE-1:0][AW-1:0]   wa,
    input  logic [NWRITE-1:0][XLEN-1:0] wd,
    input  logic [NREAD-1:0][AW-1:0]    ra,
    output logic [NREAD-1:0][XLEN-1:0]  rd
);

    logic [XLEN-1:0] r_regf [DEPTH];
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;

    regfile_clr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // Ascending loop: a later (higher-index) port overrides an earlier one.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regf[w_clr_addr] <= '0;
        end else if (!busy) begin
            for (int i = 0; i < NWRITE; i++) begin
                if (we[i] && !(ZERO_REG != 0 && wa[i] == '0))
                    r_regf[wa[i]] <= wd[i];
            end
        end
    end

    generate
        for (genvar j = 0; j < NREAD; j++) begin : g_rd
            logic [c_max_wr-1:0] w_hit;
            logic [1:0]          w_win;
            logic [XLEN-1:0]     w_byp;
            logic [XLEN-1:0]     w_rd;

            always_comb begin
                w_hit = '0;
                for (int i = 0; i < NWRITE; i++)
                    w_hit[i] = we[i] && (wa[i] == ra[j]);
                w_win = wr_winner(w_hit);
                w_byp = '0;
                for (int i = 0; i < NWRITE; i++) begin
                    if (w_win == 2'(i)) w_byp = wd[i];
                end

                if (busy)
                    w_rd = '0;
                else if (ZERO_REG != 0 && ra[j] == '0)
                    w_rd = '0;
                else if (BYPASS != 0 && (|w_hit))
                    w_rd = w_byp;
                else
                    w_rd = r_regf[ra[j]];
            end

            assign rd[j] = w_rd;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp (2W/2R bypass+x0 instance and a
//          1W/1R no-bypass, no-x0 instance sharing clock, reset and clr_req).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    logic clk;
    logic reset;
    logic clr_req;

    logic [1:0]       a_we;
    logic [1:0][4:0]  a_wa;
    logic [1:0][31:0] a_wd;
    logic [1:0][4:0]  a_ra;
    logic [1:0][31:0] a_rd;
    logic             a_busy;

    logic [0:0]       b_we;
    logic [0:0][4:0]  b_wa;
    logic [0:0][31:0] b_wd;
    logic [0:0][4:0]  b_ra;
    logic [0:0][31:0] b_rd;
    logic             b_busy;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(a_busy),
        .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra), .rd(a_rd)
    );

    regfile_mp #(
        .XLEN(32), .DEPTH(32), .NREAD(1), .NWRITE(1), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .clr_req(clr_req), .busy(b_busy),
        .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    // Expectation sources: 0 a.rd0, 1 a.rd1, 2 b.rd0, 3 a.busy, 4 b.busy
    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        bwe;
        logic [4:0]  bwa;
        logic [31:0] bwd;
        logic [4:0]  bra;
        logic [31:0] be;
    } vec_t;
    vec_t tbl [11];

    task automatic expect_v(input string n, input int src, input logic [31:0] e);
        sb_t s;
        s.name = n;
        s.src  = src;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    function automatic logic [31:0] actual(input int src);
        case (src)
            0:       return a_rd[0];
            1:       return a_rd[1];
            2:       return b_rd[0];
            3:       return {31'b0, a_busy};
            default: return {31'b0, b_busy};
        endcase
    endfunction

    task automatic check_all();
        sb_t         s;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            s   = sbq.pop_front();
            act = actual(s.src);
            checks++;
            if (act !== s.exp) begin
                failures++;
                $display("FAIL %s: got %h, required %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic cmp_int(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", n, act, exp);
        end
    endtask

    // Inputs are driven just after posedge; outputs checked at negedge.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_run(input string n, input bit poke, input int req_at, output int cnt);
        bit done;
        done = 1'b0;
        cnt  = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (poke) begin
                a_we    = 2'b11;
                a_wa[0] = 5'd1;  a_wd[0] = 32'h5555_0001;
                a_wa[1] = 5'd2;  a_wd[1] = 32'h5555_0002;
                a_ra[0] = 5'd1;  a_ra[1] = 5'd2;
            end
            clr_req = (k == req_at);
            @(negedge clk);
            if (!a_busy) begin
                done    = 1'b1;
                a_we    = '0;
                clr_req = 1'b0;
            end else begin
                cnt++;
                expect_v($sformatf("%s.b_busy[%0d]", n, k), 4, 32'h1);
                if (poke) begin
                    expect_v($sformatf("%s.a_rd0_busy[%0d]", n, k), 0, 32'h0);
                    expect_v($sformatf("%s.a_rd1_busy[%0d]", n, k), 1, 32'h0);
                end
                check_all();
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_all(input string n);
        a_we = '0;
        b_we = '0;
        for (int a = 0; a < 32; a++) begin
            a_ra[0] = 5'(a);
            a_ra[1] = 5'(31 - a);
            b_ra[0] = 5'(a);
            expect_v($sformatf("%s.a_rd0[x%0d]", n, a), 0, 32'h0);
            expect_v($sformatf("%s.a_rd1[x%0d]", n, 31 - a), 1, 32'h0);
            expect_v($sformatf("%s.b_rd0[x%0d]", n, a), 2, 32'h0);
            tick();
        end
    endtask

    initial begin
        int cnt;

        //           we     wa1    wd1            wa0    wd0            ra0    ra1    e0             e1             bwe   bwa    bwd            bra    be
        tbl[0]  = '{2'b01, 5'd0,  32'h0,         5'd7,  32'h1234_5678, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 1'b1, 5'd7,  32'h1234_5678, 5'd7,  32'h0};
        tbl[1]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd7,  5'd0,  32'h1234_5678, 32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  32'h1234_5678};
        tbl[2]  = '{2'b11, 5'd5,  32'hBBBB_0000, 5'd5,  32'hAAAA_0000, 5'd5,  5'd6,  32'hBBBB_0000, 32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0};
        tbl[3]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd5,  5'd7,  32'hBBBB_0000, 32'h1234_5678, 1'b0, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF};
        tbl[4]  = '{2'b01, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'hBBBB_0000, 1'b1, 5'd7,  32'h0000_0077, 5'd7,  32'h1234_5678};
        tbl[5]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0,         5'd7,  32'h0000_0077};
        tbl[6]  = '{2'b11, 5'd0,  32'hDEAD_BEEF, 5'd9,  32'h0000_0009, 5'd9,  5'd0,  32'h0000_0009, 32'h0,         1'b0, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF};
        tbl[7]  = '{2'b10, 5'd3,  32'h3333_3333, 5'd9,  32'h2222_2222, 5'd9,  5'd3,  32'h0000_0009, 32'h3333_3333, 1'b1, 5'd31, 32'h3131_3131, 5'd31, 32'h0};
        tbl[8]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd3,  5'd9,  32'h3333_3333, 32'h0000_0009, 1'b0, 5'd0,  32'h0,         5'd31, 32'h3131_3131};
        tbl[9]  = '{2'b11, 5'd12, 32'h0000_C0C0, 5'd13, 32'h0000_D0D0, 5'd12, 5'd13, 32'h0000_C0C0, 32'h0000_D0D0, 1'b0, 5'd0,  32'h0,         5'd1,  32'h0};
        tbl[10] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         5'd13, 5'd12, 32'h0000_D0D0, 32'h0000_C0C0, 1'b0, 5'd0,  32'h0,         5'd0,  32'hFFFF_FFFF};

        reset   = 1'b1;
        clr_req = 1'b0;
        a_we = '0; a_wa = '0; a_wd = '0;
        b_we = '0; b_wa = '0; b_wd = '0;
        a_ra[0] = 5'd3; a_ra[1] = 5'd4; b_ra[0] = 5'd5;

        // Reset state
        expect_v("reset.a_busy", 3, 32'h1);
        expect_v("reset.b_busy", 4, 32'h1);
        expect_v("reset.a_rd0", 0, 32'h0);
        expect_v("reset.a_rd1", 1, 32'h0);
        expect_v("reset.b_rd0", 2, 32'h0);
        tick();
        reset = 1'b0;
        busy_run("init", 1'b0, -1, cnt);
        cmp_int("init.busy_cycles", cnt, 32);
        read_all("init");

        // Priority, bypass and x0 vectors
        for (int i = 0; i < 11; i++) begin
            a_we    = tbl[i].we;
            a_wa[1] = tbl[i].wa1; a_wd[1] = tbl[i].wd1;
            a_wa[0] = tbl[i].wa0; a_wd[0] = tbl[i].wd0;
            a_ra[0] = tbl[i].ra0; a_ra[1] = tbl[i].ra1;
            b_we[0] = tbl[i].bwe; b_wa[0] = tbl[i].bwa; b_wd[0] = tbl[i].bwd;
            b_ra[0] = tbl[i].bra;
            expect_v($sformatf("vec%0d.a_rd0", i), 0, tbl[i].e0);
            expect_v($sformatf("vec%0d.a_rd1", i), 1, tbl[i].e1);
            expect_v($sformatf("vec%0d.b_rd0", i), 2, tbl[i].be);
            tick();
        end
        a_we = '0;
        b_we = '0;

        // Fill x1..x31, then soft clear with writes attempted and a second request mid-clear
        for (int a = 1; a < 32; a += 2) begin
            a_we[0] = 1'b1;
            a_we[1] = (a + 1 < 32);
            a_wa[0] = 5'(a);     a_wd[0] = 32'hA500_0000 | 32'(a);
            a_wa[1] = 5'(a + 1); a_wd[1] = 32'hA500_0000 | 32'(a + 1);
            a_ra[0] = 5'(a);     a_ra[1] = 5'(a);
            expect_v($sformatf("fill.a_rd0[x%0d]", a), 0, 32'hA500_0000 | 32'(a));
            tick();
        end
        a_we = '0;
        a_ra[0] = 5'd17; a_ra[1] = 5'd30;
        expect_v("fill.readback17", 0, 32'hA500_0011);
        expect_v("fill.readback30", 1, 32'hA500_001E);
        tick();

        clr_req = 1'b1;
        expect_v("clr.pulse_a_busy", 3, 32'h0);
        tick();
        clr_req = 1'b0;
        busy_run("clr", 1'b1, 10, cnt);
        cmp_int("clr.busy_cycles", cnt, 32);
        read_all("after_clr");

        // Reset arriving with ptr at 10 restarts the clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_v($sformatf("rst_mid.a_busy[%0d]", k), 3, 32'h1);
            tick();
        end
        reset = 1'b1;
        a_ra[0] = 5'd5; a_ra[1] = 5'd6; b_ra[0] = 5'd7;
        expect_v("rst_mid.a_busy", 3, 32'h1);
        expect_v("rst_mid.a_rd0", 0, 32'h0);
        expect_v("rst_mid.b_rd0", 2, 32'h0);
        tick();
        reset = 1'b0;
        busy_run("rst_mid", 1'b0, -1, cnt);
        cmp_int("rst_mid.busy_cycles", cnt, 32);
        read_all("after_rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
